// File: rtl/chain_code_pkg.sv
// Shared definitions for chain-code contour tools: image geometry, direction codes,
// step lookup and the decoder state encoding.
package chain_code_pkg;

  localparam int unsigned IMG_W   = 64;
  localparam int unsigned COORD_W = 6;
  localparam int unsigned STEP_W  = 7;

  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_NW = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_SE = 3'd7;

  typedef enum logic [2:0] {
    StIdle, StClear, StFetch, StFetchWait, StDraw, StFlush, StDone
  } dec_state_e;

  function automatic logic signed [1:0] dir_dx(input logic [2:0] code);
    case (code)
      DIR_E, DIR_NE, DIR_SE: dir_dx = 2'sb01;
      DIR_NW, DIR_W, DIR_SW: dir_dx = 2'sb11;
      default:               dir_dx = 2'sb00;
    endcase
  endfunction

  // Row index grows downward, so "north" is -y.
  function automatic logic signed [1:0] dir_dy(input logic [2:0] code);
    case (code)
      DIR_NE, DIR_N, DIR_NW: dir_dy = 2'sb11;
      DIR_SW, DIR_S, DIR_SE: dir_dy = 2'sb01;
      default:               dir_dy = 2'sb00;
    endcase
  endfunction

  // Pixel x lives at bit 63-x, which is simply ~x for a 6-bit coordinate.
  function automatic logic [IMG_W-1:0] pix_mask(input logic [COORD_W-1:0] x);
    pix_mask = '0;
    pix_mask[~x] = 1'b1;
  endfunction

endpackage

// File: rtl/chain_step.sv
// Combinational single step of a Freeman chain code: next position and bounds check.
module chain_step
  import chain_code_pkg::*;
(
  input  logic [COORD_W-1:0] i_cur_x,
  input  logic [COORD_W-1:0] i_cur_y,
  input  logic [2:0]         i_code,
  output logic [COORD_W-1:0] o_next_x,
  output logic [COORD_W-1:0] o_next_y,
  output logic               o_out_of_bounds
);

  logic signed [1:0]        w_dx;
  logic signed [1:0]        w_dy;
  logic signed [STEP_W-1:0] w_sx;
  logic signed [STEP_W-1:0] w_sy;

  assign w_dx = dir_dx(i_code);
  assign w_dy = dir_dy(i_code);
  assign w_sx = $signed({1'b0, i_cur_x}) + $signed({{(STEP_W-2){w_dx[1]}}, w_dx});
  assign w_sy = $signed({1'b0, i_cur_y}) + $signed({{(STEP_W-2){w_dy[1]}}, w_dy});

  assign o_next_x = w_sx[COORD_W-1:0];
  assign o_next_y = w_sy[COORD_W-1:0];
  // Both -1 and 64 land with the top bit of the 7-bit sum set.
  assign o_out_of_bounds = w_sx[STEP_W-1] | w_sy[STEP_W-1];

endmodule

// File: rtl/chain_decoder.sv
// Redraws a Freeman chain-code contour into a 64x64 row-organised image RAM.
// Define CHAIN_DEC_CLEAR_EN to zero the whole image after start, before drawing.
module chain_decoder
  import chain_code_pkg::*;
(
  input  logic               Clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic               code_valid,
  input  logic [2:0]         code,
  input  logic               code_last,
  output logic               code_ready,
  output logic [COORD_W-1:0] rd_addr,
  input  logic [IMG_W-1:0]   rd_data,
  output logic               wr_en,
  output logic [COORD_W-1:0] wr_addr,
  output logic [IMG_W-1:0]   wr_data,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic [7:0]         perimeter,
  output logic               busy,
  output logic               done,
  output logic               closed,
  output logic               error
);

`ifdef CHAIN_DEC_CLEAR_EN
  localparam dec_state_e FirstState = StClear;
`else
  localparam dec_state_e FirstState = StFetch;
`endif

  dec_state_e         r_state, w_state_next;
  logic [COORD_W-1:0] r_cur_x, r_cur_y, r_start_x, r_start_y;
  logic [COORD_W-1:0] r_cache_row, r_clr_cnt;
  logic [IMG_W-1:0]   r_cache;
  logic [7:0]         r_perim;
  logic               r_closed, r_error, r_last_pend;

  logic [COORD_W-1:0] w_next_x, w_next_y;
  logic               w_oob, w_same_row;

  chain_step u_step (
    .i_cur_x         (r_cur_x),
    .i_cur_y         (r_cur_y),
    .i_code          (code),
    .o_next_x        (w_next_x),
    .o_next_y        (w_next_y),
    .o_out_of_bounds (w_oob)
  );

  assign w_same_row = (w_next_y == r_cache_row);

  always_ff @(posedge Clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (start) w_state_next = FirstState;
      StClear:        if (r_clr_cnt == '1) w_state_next = StFetch;
      StFetch:        w_state_next = StFetchWait;
      StFetchWait:    w_state_next = r_last_pend ? StFlush : StDraw;
      StDraw: begin
        if (code_valid) begin
          if (w_oob)            w_state_next = StDone;
          else if (!w_same_row) w_state_next = StFetch;
          else if (code_last)   w_state_next = StFlush;
        end
      end
      StFlush:        w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_comb begin
    code_ready = 1'b0;
    rd_addr    = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    unique case (r_state)
      StClear: begin
        wr_en   = 1'b1;
        wr_addr = r_clr_cnt;
      end
      StFetch: rd_addr = r_cur_y;
      StDraw: begin
        code_ready = 1'b1;
        // Leaving the cached row: write it back in the same cycle as the step.
        if (code_valid && !w_oob && !w_same_row) begin
          wr_en   = 1'b1;
          wr_addr = r_cache_row;
          wr_data = r_cache;
        end
      end
      StFlush: begin
        wr_en   = 1'b1;
        wr_addr = r_cache_row;
        wr_data = r_cache;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_start_x   <= '0;
      r_start_y   <= '0;
      r_cache_row <= '0;
      r_clr_cnt   <= '0;
      r_cache     <= '0;
      r_perim     <= '0;
      r_closed    <= 1'b0;
      r_error     <= 1'b0;
      r_last_pend <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_cur_x     <= start_x;
            r_cur_y     <= start_y;
            r_start_x   <= start_x;
            r_start_y   <= start_y;
            r_perim     <= '0;
            r_closed    <= 1'b0;
            r_error     <= 1'b0;
            r_last_pend <= 1'b0;
            r_clr_cnt   <= '0;
          end
        end
        StClear: r_clr_cnt <= r_clr_cnt + 6'd1;
        StFetchWait: begin
          r_cache     <= rd_data | pix_mask(r_cur_x);
          r_cache_row <= r_cur_y;
        end
        StDraw: begin
          if (code_valid) begin
            if (w_oob) begin
              r_error <= 1'b1;
            end else begin
              if (r_perim != 8'hff) r_perim <= r_perim + 8'd1;
              r_cur_x <= w_next_x;
              r_cur_y <= w_next_y;
              if (w_same_row) r_cache <= r_cache | pix_mask(w_next_x);
              if (code_last) begin
                r_closed    <= (w_next_x == r_start_x) && (w_next_y == r_start_y);
                r_last_pend <= !w_same_row;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cur_x     = r_cur_x;
  assign cur_y     = r_cur_y;
  assign perimeter = r_perim;
  assign closed    = r_closed;
  assign error     = r_error;
  assign done      = (r_state == StDone);
  assign busy      = (r_state != StIdle) && (r_state != StDone);

endmodule

// File: tb/tb_chain_decoder.sv
// Scoreboard bench for chain_decoder: expected RAM writes and done results are queued
// by the stimulus and checked by an independent monitor.
module tb_chain_decoder;

  logic        Clk = 1'b0;
  logic        reset, start, code_valid, code_last;
  logic [5:0]  start_x, start_y;
  logic [2:0]  code;
  logic        code_ready, wr_en, busy, done, closed, error;
  logic [5:0]  rd_addr, wr_addr, cur_x, cur_y;
  logic [63:0] rd_data, wr_data;
  logic [7:0]  perimeter;

  always #5 Clk = ~Clk;

  chain_decoder dut (
    .Clk        (Clk),
    .reset      (reset),
    .start      (start),
    .start_x    (start_x),
    .start_y    (start_y),
    .code_valid (code_valid),
    .code       (code),
    .code_last  (code_last),
    .code_ready (code_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .perimeter  (perimeter),
    .busy       (busy),
    .done       (done),
    .closed     (closed),
    .error      (error)
  );

  // Image RAM model: 1-cycle read latency, no bypass.
  logic [63:0] mem [64];
  logic [63:0] rd_q;
  logic        ram_fill = 1'b0;
  logic [63:0] ram_fill_val = '0;
  always @(posedge Clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 64; i++) mem[i] <= ram_fill_val;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[rd_addr];
  end
  assign rd_data = rd_q;

`ifdef CHAIN_DEC_CLEAR_EN
  localparam int Lat = 66;
`else
  localparam int Lat = 2;
`endif

  typedef struct packed {logic [5:0] addr; logic [63:0] data;} wr_t;
  typedef struct packed {
    logic [7:0] perim; logic cl; logic err; logic [5:0] x; logic [5:0] y;
  } res_t;

  wr_t  wq[$];
  res_t dq[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic done_q = 1'b0;
  logic run_clr = 1'b0;
  int   run_cur = 0;
  int   run_max = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] px(input int x);
    logic [63:0] m;
    m = 64'd1;
    return m << (63 - x);
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m |= px(i);
    return m;
  endfunction

  // Monitor: compares every RAM write and every rising done against the queues.
  always @(negedge Clk) begin
    if (wr_en) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: row %0d data %h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(w.addr));
        check("wr_data", wr_data, w.data);
      end
    end
    if (done && !done_q) begin
      if (dq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: perimeter %0d, expected no done", perimeter);
      end else begin
        res_t r;
        r = dq.pop_front();
        check("done_perimeter", 64'(perimeter), 64'(r.perim));
        check("done_closed", 64'(closed), 64'(r.cl));
        check("done_error", 64'(error), 64'(r.err));
        check("done_pos", 64'({cur_x, cur_y}), 64'({r.x, r.y}));
      end
    end
    done_q <= done;
    if (run_clr) begin
      run_cur <= 0;
      run_max <= 0;
    end else if (code_ready && code_valid) begin
      run_cur <= run_cur + 1;
      if (run_cur + 1 > run_max) run_max <= run_cur + 1;
    end else begin
      run_cur <= 0;
    end
  end

  task automatic push_wr(input int addr, input logic [63:0] data);
    wr_t w;
    w.addr = 6'(addr);
    w.data = data;
    wq.push_back(w);
  endtask

  task automatic push_res(input int p, input logic cl, input logic err, input int x, input int y);
    res_t r;
    r.perim = 8'(p);
    r.cl    = cl;
    r.err   = err;
    r.x     = 6'(x);
    r.y     = 6'(y);
    dq.push_back(r);
  endtask

  task automatic push_clear();
`ifdef CHAIN_DEC_CLEAR_EN
    for (int i = 0; i < 64; i++) push_wr(i, 64'd0);
`endif
  endtask

  task automatic fill_ram(input logic [63:0] v);
    @(posedge Clk); #1;
    ram_fill_val = v;
    ram_fill = 1'b1;
    @(posedge Clk); #1;
    ram_fill = 1'b0;
  endtask

  task automatic do_start(input int x, input int y);
    int n = 0;
    @(posedge Clk); #1;
    start = 1'b1;
    start_x = 6'(x);
    start_y = 6'(y);
    @(posedge Clk); #1;
    start = 1'b0;
    while (n < 300) begin
      @(negedge Clk);
      if (code_ready) break;
      n++;
    end
    check("start_latency", 64'(n), 64'(Lat));
  endtask

  task automatic send_code(input logic [2:0] c, input logic last);
    int n = 0;
    code_valid = 1'b1;
    code = c;
    code_last = last;
    while (!code_ready && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL code_accept_timeout: code_ready 0, expected 1");
    end
    @(posedge Clk); #1;
    if (last) code_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      @(posedge Clk); #1;
      n++;
    end
    check(name, 64'(done), 64'd1);
    repeat (2) @(posedge Clk);
    #1;
    check({name, "_wq_empty"}, 64'(wq.size()), 64'd0);
    check({name, "_dq_empty"}, 64'(dq.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string p);
    check({p, "_ctl"}, 64'({code_ready, wr_en, busy, done, closed, error}), 64'd0);
    check({p, "_addr"}, 64'({rd_addr, wr_addr}), 64'd0);
    check({p, "_wr_data"}, wr_data, 64'd0);
    check({p, "_cur"}, 64'({cur_x, cur_y}), 64'd0);
    check({p, "_perimeter"}, 64'(perimeter), 64'd0);
  endtask

  initial begin
    logic [2:0] sq [8];
    sq = '{3'd0, 3'd0, 3'd6, 3'd6, 3'd4, 3'd4, 3'd2, 3'd2};
    reset = 1'b1;
    start = 1'b0;
    start_x = '0;
    start_y = '0;
    code_valid = 1'b0;
    code = '0;
    code_last = 1'b0;
    ram_fill_val = '0;
    ram_fill = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    ram_fill = 1'b0;
    check_all_zero("reset");
    reset = 1'b0;

    // Closed 3x3 square.
    fill_ram(64'd0);
    push_clear();
    push_wr(10, span(10, 12));
    push_wr(11, px(12));
    push_wr(12, span(10, 12));
    push_wr(11, px(10) | px(12));
    push_wr(10, span(10, 12));
    push_res(8, 1'b1, 1'b0, 10, 10);
    do_start(10, 10);
    for (int i = 0; i < 8; i++) send_code(sq[i], i == 7);
    wait_done("square_done");
    check("square_row10", mem[10], span(10, 12));
    check("square_row11", mem[11], px(10) | px(12));
    check("square_row12", mem[12], span(10, 12));

    // Step off the right edge.
    push_clear();
    push_res(0, 1'b0, 1'b1, 63, 5);
    do_start(63, 5);
    send_code(3'd0, 1'b1);
    wait_done("oob_done");

    // Back-to-back same-row codes.
    push_clear();
    push_wr(20, span(0, 5));
    push_res(5, 1'b0, 1'b0, 5, 20);
    run_clr = 1'b1;
    @(posedge Clk); #1;
    run_clr = 1'b0;
    do_start(0, 20);
    for (int i = 0; i < 5; i++) send_code(3'd0, i == 4);
    wait_done("thru_done");
    check("thru_ready_run", 64'(run_max), 64'd5);
    check("thru_row20", mem[20], span(0, 5));

    // Open chain ending one row down.
    fill_ram(64'd0);
    push_clear();
    push_wr(0, px(0) | px(1));
    push_wr(1, px(2));
    push_res(2, 1'b0, 1'b0, 2, 1);
    do_start(0, 0);
    send_code(3'd0, 1'b0);
    send_code(3'd7, 1'b1);
    wait_done("open_done");
    check("open_row0", mem[0], px(0) | px(1));
    check("open_row1", mem[1], px(2));

`ifdef CHAIN_DEC_CLEAR_EN
    // Clear over an all-ones image.
    fill_ram('1);
    push_clear();
    push_wr(30, px(30));
    push_wr(31, px(30));
    push_wr(30, px(30));
    push_res(2, 1'b1, 1'b0, 30, 30);
    do_start(30, 30);
    send_code(3'd6, 1'b0);
    send_code(3'd2, 1'b1);
    wait_done("clear_done");
    check("clear_row30", mem[30], px(30));
    check("clear_row31", mem[31], px(30));
    check("clear_row0", mem[0], 64'd0);
    check("clear_row63", mem[63], 64'd0);
`endif

    // Reset in the middle of drawing.
    push_clear();
    do_start(40, 40);
    for (int i = 0; i < 3; i++) send_code(3'd0, 1'b0);
    code_valid = 1'b0;
    check("mid_perimeter", 64'(perimeter), 64'd3);
    check("mid_cur_x", 64'(cur_x), 64'd43);
    reset = 1'b1;
    @(posedge Clk); #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    check("mid_wq_empty", 64'(wq.size()), 64'd0);
    check("mid_idle", 64'({busy, done}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
